// File: rtl/imm_chunk_issuer.sv
// Serialises a D_WIDTH constant into MSB-first immediate instruction words
// ({write-enable, C-bit payload}) for an immediate-unit lane.
module imm_chunk_issuer #(
  parameter int I_IMM_WIDTH = 12,
  parameter int D_WIDTH     = 32
) (
  input  logic                   iClk,
  input  logic                   iReset,
  input  logic                   iStall,
  input  logic                   iValid,
  input  logic [D_WIDTH-1:0]     iData,
  output logic                   oReady,
  output logic [I_IMM_WIDTH-1:0] oInstruction,
  output logic                   oBusy,
  output logic                   oLast
);
  localparam int C  = I_IMM_WIDTH - 1;
  localparam int N  = (D_WIDTH + C - 1) / C;
  localparam int NC = N * C;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                 state_q, state_d;
  logic [NC-1:0]          data_q, data_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [I_IMM_WIDTH-1:0] instr_q, instr_d;
  logic [NC-1:0]          load_ext, shifted;
  logic                   accept;

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
    end
  end

  // The next chunk is always the top C bits; data is shifted up as it issues.
  always_comb begin
    load_ext                = '0;
    load_ext[D_WIDTH-1:0]   = iData;
    shifted                 = data_q << C;
    oBusy                   = (state_q == ISSUE);
    oLast                   = oBusy && (cnt_q == '0);
    oReady                  = !oBusy || (oLast && !iStall);
    accept                  = iValid && oReady;
    state_d                 = state_q;
    data_d                  = data_q;
    cnt_d                   = cnt_q;
    instr_d                 = instr_q;
    if (accept) begin
      // IDLE accepts even when stalled: an IDLE NOP has nothing to hold.
      data_d  = load_ext;
      instr_d = {1'b1, load_ext[NC-1 -: C]};
      cnt_d   = CW'(N - 1);
      state_d = ISSUE;
    end else if (oBusy && !iStall) begin
      if (cnt_q != '0) begin
        data_d  = shifted;
        instr_d = {1'b1, shifted[NC-1 -: C]};
        cnt_d   = cnt_q - 1'b1;
      end else begin
        instr_d = '0;
        state_d = IDLE;
      end
    end
  end

  assign oInstruction = instr_q;

endmodule

// File: tb/tb_imm_chunk_issuer.sv
// Directed bench for imm_chunk_issuer: N=3 (D=32) instance plus an N=1 (D=8) instance.
module tb_imm_chunk_issuer;
  logic        iClk = 1'b0;
  logic        iReset;
  logic        iStall, iValid;
  logic [31:0] iData;
  logic        oReady, oBusy, oLast;
  logic [11:0] oInstruction;

  logic        iStall2, iValid2;
  logic [7:0]  iData2;
  logic        oReady2, oBusy2, oLast2;
  logic [11:0] oInstruction2;

  int total = 0;
  int bad   = 0;
  logic [32:0] iu;

  imm_chunk_issuer #(.I_IMM_WIDTH(12), .D_WIDTH(32)) u_dut (
    .iClk(iClk), .iReset(iReset), .iStall(iStall), .iValid(iValid), .iData(iData),
    .oReady(oReady), .oInstruction(oInstruction), .oBusy(oBusy), .oLast(oLast)
  );

  imm_chunk_issuer #(.I_IMM_WIDTH(12), .D_WIDTH(8)) u_dut1 (
    .iClk(iClk), .iReset(iReset), .iStall(iStall2), .iValid(iValid2), .iData(iData2),
    .oReady(oReady2), .oInstruction(oInstruction2), .oBusy(oBusy2), .oLast(oLast2)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Word, oLast, oBusy, oReady of the N=3 instance in one go.
  task automatic wchk(input string tag, input logic [11:0] w, input logic last,
                      input logic busy, input logic rdy);
    chk({tag, ".word"}, 32'(oInstruction), 32'(w));
    chk({tag, ".last"}, 32'(oLast), 32'(last));
    chk({tag, ".busy"}, 32'(oBusy), 32'(busy));
    chk({tag, ".rdy"},  32'(oReady), 32'(rdy));
    if (oInstruction[11]) iu = {iu[21:0], oInstruction[10:0]};
  endtask

  initial begin
    iReset = 1'b0; iStall = 1'b0; iValid = 1'b0; iData = '0;
    iStall2 = 1'b0; iValid2 = 1'b0; iData2 = '0;
    iu = '0;
    #12;
    wchk("rst", 12'h000, 1'b0, 1'b0, 1'b1);
    chk("rst.rdy1", 32'(oReady2), 32'd1);
    tick();
    iReset = 1'b1;
    tick();
    wchk("idle", 12'h000, 1'b0, 1'b0, 1'b1);

    // single constant
    iValid = 1'b1; iData = 32'hDEADBEEF;
    tick(); iValid = 1'b0; iData = 32'h0;
    wchk("s0", 12'hB7A, 1'b0, 1'b1, 1'b0);
    tick(); wchk("s1", 12'hDB7, 1'b0, 1'b1, 1'b0);
    tick(); wchk("s2", 12'hEEF, 1'b1, 1'b1, 1'b1);
    chk("s.iu", iu[31:0], 32'hDEADBEEF);
    tick(); wchk("s3", 12'h000, 1'b0, 1'b0, 1'b1);

    // back-to-back, iValid held; second accept in the oLast cycle
    iValid = 1'b1; iData = 32'h00000001;
    tick(); iData = 32'hFFFFFFFF;
    wchk("b0", 12'h800, 1'b0, 1'b1, 1'b0);
    tick(); wchk("b1", 12'h800, 1'b0, 1'b1, 1'b0);
    tick(); wchk("b2", 12'h801, 1'b1, 1'b1, 1'b1);
    tick(); iValid = 1'b0;
    wchk("b3", 12'hBFF, 1'b0, 1'b1, 1'b0);
    tick(); wchk("b4", 12'hFFF, 1'b0, 1'b1, 1'b0);
    tick(); wchk("b5", 12'hFFF, 1'b1, 1'b1, 1'b1);
    tick(); wchk("b6", 12'h000, 1'b0, 1'b0, 1'b1);

    // stall mid-sequence for 2 cycles on the second word
    iValid = 1'b1; iData = 32'hDEADBEEF;
    tick(); iValid = 1'b0;
    wchk("m0", 12'hB7A, 1'b0, 1'b1, 1'b0);
    tick(); iStall = 1'b1;
    wchk("m1", 12'hDB7, 1'b0, 1'b1, 1'b0);
    tick(); wchk("m2", 12'hDB7, 1'b0, 1'b1, 1'b0);
    tick(); iStall = 1'b0;
    wchk("m3", 12'hDB7, 1'b0, 1'b1, 1'b0);
    tick(); wchk("m4", 12'hEEF, 1'b1, 1'b1, 1'b1);
    tick(); wchk("m5", 12'h000, 1'b0, 1'b0, 1'b1);

    // stall during oLast with iValid pending
    iValid = 1'b1; iData = 32'h00000001;
    tick(); iData = 32'hFFFFFFFF;
    tick();
    tick(); iStall = 1'b1; #1;
    wchk("l0", 12'h801, 1'b1, 1'b1, 1'b0);
    tick(); wchk("l1", 12'h801, 1'b1, 1'b1, 1'b0);
    iStall = 1'b0; #1;
    chk("l1.rdy", 32'(oReady), 32'd1);
    tick(); iValid = 1'b0;
    wchk("l2", 12'hBFF, 1'b0, 1'b1, 1'b0);
    tick(); tick();
    wchk("l3", 12'hFFF, 1'b1, 1'b1, 1'b1);
    tick(); wchk("l4", 12'h000, 1'b0, 1'b0, 1'b1);

    // async reset between edges during word 2
    iValid = 1'b1; iData = 32'hDEADBEEF;
    tick(); iValid = 1'b0;
    tick(); wchk("r0", 12'hDB7, 1'b0, 1'b1, 1'b0);
    #2 iReset = 1'b0; #1;
    wchk("r1", 12'h000, 1'b0, 1'b0, 1'b1);
    tick(); iReset = 1'b1;
    wchk("r2", 12'h000, 1'b0, 1'b0, 1'b1);
    iValid = 1'b1; iData = 32'h12345678;
    tick(); iValid = 1'b0;
    wchk("r3", 12'h848, 1'b0, 1'b1, 1'b0);
    tick(); wchk("r4", 12'hE8A, 1'b0, 1'b1, 1'b0);
    tick(); wchk("r5", 12'hE78, 1'b1, 1'b1, 1'b1);
    tick(); wchk("r6", 12'h000, 1'b0, 1'b0, 1'b1);

    // N=1 instance
    iValid2 = 1'b1; iData2 = 8'hA5;
    tick(); iData2 = 8'h3C;
    chk("n0.word", 32'(oInstruction2), 32'h8A5);
    chk("n0.last", 32'(oLast2), 32'd1);
    chk("n0.rdy",  32'(oReady2), 32'd1);
    tick(); iStall2 = 1'b1; #1;
    chk("n1.word", 32'(oInstruction2), 32'h83C);
    chk("n1.rdy",  32'(oReady2), 32'd0);
    tick(); iStall2 = 1'b0; iValid2 = 1'b0;
    chk("n2.word", 32'(oInstruction2), 32'h83C);
    tick();
    chk("n3.word", 32'(oInstruction2), 32'h000);
    chk("n3.busy", 32'(oBusy2), 32'd0);
    // IDLE accept is taken even under stall
    iStall2 = 1'b1; iValid2 = 1'b1; iData2 = 8'h5A; #1;
    chk("n4.rdy", 32'(oReady2), 32'd1);
    tick(); iValid2 = 1'b0;
    chk("n4.word", 32'(oInstruction2), 32'h85A);
    chk("n4.last", 32'(oLast2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
